// File: rtl/mluart_pkg.sv
// mluart_pkg: shared definitions for the mluart receiver/transmitter family.
// Holds the FSM state encoding, legal parameter ranges and small bit helpers.
package mluart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } mluart_state_t;

  localparam int unsigned DATA_BITS_MIN  = 32'd5;
  localparam int unsigned DATA_BITS_MAX  = 32'd9;
  localparam int unsigned OVERSAMPLE_MIN = 32'd8;
  localparam int unsigned OVERSAMPLE_MAX = 32'd32;

  // Majority of three samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Reduction XOR over a word of up to DATA_BITS_MAX bits (zero-extend narrower words).
  function automatic logic xor9(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mluart_rx_sync.sv
// mluart_rx_sync: two-flop synchroniser for the raw UART line plus a 3-tap
// majority filter. Taps are taken on oversample ticks only; 'vote' is the
// majority of the two previous tick samples and the current synchronised line.
module mluart_rx_sync
  import mluart_pkg::*;
(
  input  logic CLK_100MHZ,
  input  logic reset,
  input  logic clk_en_os,
  input  logic UART_RX,
  output logic rx_s,
  output logic vote
);

  logic       meta_r;
  logic       sync_r;
  logic [1:0] hist_r;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= UART_RX;
      sync_r <= meta_r;
    end
  end

  // Keep the last two tick samples so the vote covers three consecutive ticks.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      hist_r <= 2'b11;
    end else if (clk_en_os) begin
      hist_r <= {hist_r[0], sync_r};
    end
  end

  assign rx_s = sync_r;
  assign vote = maj3(hist_r[1], hist_r[0], sync_r);

endmodule

// File: rtl/mluart_rx_param.sv
// mluart_rx_param: parametrised UART receiver with majority-vote sampling,
// false-start rejection, framing/overrun flags and a valid/ack handshake.
// Optional parity bit enabled by defining MLUART_RX_PARITY_EN.
module mluart_rx_param
  import mluart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 CLK_100MHZ,
  input  logic                 reset,
  input  logic                 clk_en_os,
  input  logic                 UART_RX,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] VOTE_AT   = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_BITS - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  mluart_state_t        state_r, state_nx_s;
  logic [OSW-1:0]       os_cnt_r;
  logic [BCW-1:0]       bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 stop_idx_r;
  logic                 stop_bad_r;
  logic                 rx_s;
  logic                 vote_s;
  logic                 vote_tick_s;
  logic                 last_tick_s;
  logic                 done_s;
  logic                 ack_s;
  logic                 parity_s;

  mluart_rx_sync u_sync (
    .CLK_100MHZ (CLK_100MHZ),
    .reset      (reset),
    .clk_en_os  (clk_en_os),
    .UART_RX    (UART_RX),
    .rx_s       (rx_s),
    .vote       (vote_s)
  );

  assign vote_tick_s = clk_en_os && (os_cnt_r == VOTE_AT);
  assign last_tick_s = clk_en_os && (os_cnt_r == OS_LAST);
  assign ack_s       = data_ack & data_valid;

  // State register.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; the final stop vote both completes the word and
  // returns to IDLE half a bit early so the next start edge is caught.
  always_comb begin
    state_nx_s = state_r;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clk_en_os && !rx_s) begin
          state_nx_s = ST_START;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (vote_tick_s && vote_s) begin
          state_nx_s = ST_IDLE;
        end else if (last_tick_s) begin
          state_nx_s = ST_DATA;
        end else begin
          state_nx_s = ST_START;
        end
      end
      ST_DATA: begin
        if (last_tick_s && (bit_cnt_r == BIT_LAST)) begin
`ifdef MLUART_RX_PARITY_EN
          state_nx_s = ST_PARITY;
`else
          state_nx_s = ST_STOP;
`endif
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_PARITY: begin
`ifdef MLUART_RX_PARITY_EN
        if (last_tick_s) begin
          state_nx_s = ST_STOP;
        end else begin
          state_nx_s = ST_PARITY;
        end
`else
        state_nx_s = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (vote_tick_s && (stop_idx_r == STOP_LAST)) begin
          state_nx_s = ST_IDLE;
          done_s     = 1'b1;
        end else begin
          state_nx_s = ST_STOP;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Oversample counter, bit counter, shift register and stop-bit tracking; all advance on ticks only.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      os_cnt_r   <= '0;
      bit_cnt_r  <= '0;
      shift_r    <= '0;
      stop_idx_r <= 1'b0;
      stop_bad_r <= 1'b0;
    end else if (clk_en_os) begin
      if (state_nx_s != state_r) begin
        os_cnt_r <= '0;
      end else if (os_cnt_r == OS_LAST) begin
        os_cnt_r <= '0;
      end else begin
        os_cnt_r <= os_cnt_r + OSW'(1);
      end
      case (state_r)
        ST_START: begin
          bit_cnt_r  <= '0;
          stop_idx_r <= 1'b0;
          stop_bad_r <= 1'b0;
        end
        ST_DATA: begin
          if (vote_tick_s) begin
            shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
          end
          if (last_tick_s) begin
            bit_cnt_r <= bit_cnt_r + BCW'(1);
          end
        end
        ST_STOP: begin
          if (vote_tick_s && !vote_s) begin
            stop_bad_r <= 1'b1;
          end
          if (last_tick_s) begin
            stop_idx_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MLUART_RX_PARITY_EN
  localparam logic PAR_SENSE = 1'(PARITY_ODD);
  logic par_bit_r;

  // Capture the voted parity bit.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      par_bit_r <= 1'b0;
    end else if (vote_tick_s && (state_r == ST_PARITY)) begin
      par_bit_r <= vote_s;
    end
  end

  assign parity_s = ((xor9(9'(shift_r)) ^ par_bit_r) != PAR_SENSE);
`else
  assign parity_s = 1'b0;
`endif

  // Output word, status flags and consumer handshake; runs every clock.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else if (done_s) begin
      data_out   <= shift_r;
      data_valid <= 1'b1;
      frame_err  <= stop_bad_r | ~vote_s;
      parity_err <= parity_s;
      if (data_valid && !data_ack) begin
        overrun_err <= 1'b1;
      end else if (ack_s) begin
        overrun_err <= 1'b0;
      end
    end else if (ack_s) begin
      data_valid  <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mluart_rx_param.sv
// tb_mluart_rx_param: table-driven directed frames, hand-written corner
// sequences and randomised frames checked against a frame-level model.
module tb_mluart_rx_param;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int SB       = 1;
  localparam int BIT_CLKS = OS * 4;
`ifdef MLUART_RX_PARITY_EN
  localparam int PODD    = 1;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int PODD    = 0;
  localparam bit HAS_PAR = 1'b0;
`endif

  logic          CLK_100MHZ = 1'b0;
  logic          reset      = 1'b1;
  logic          clk_en_os  = 1'b0;
  logic          UART_RX    = 1'b1;
  logic          data_ack   = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;
  int            tick_div   = 0;

  mluart_rx_param #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_BITS (SB),
    .PARITY_ODD(PODD)
  ) dut (
    .CLK_100MHZ (CLK_100MHZ),
    .reset      (reset),
    .clk_en_os  (clk_en_os),
    .UART_RX    (UART_RX),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun_err(overrun_err)
  );

  initial forever #5 CLK_100MHZ = ~CLK_100MHZ;

  // One oversample tick every 4 clocks.
  always @(posedge CLK_100MHZ) begin
    tick_div  <= (tick_div == 3) ? 0 : tick_div + 1;
    clk_en_os <= (tick_div == 3);
  end

  int n_vec = 0;
  int n_bad = 0;

  // Frame-level reference model.
  logic [DB-1:0] m_data = '0;
  logic m_pend = 1'b0, m_ovr = 1'b0, m_fe = 1'b0, m_pe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic good_par(input logic [DB-1:0] d);
    return (^d) ^ 1'(PODD);
  endfunction

  task automatic line_bit(input logic v);
    UART_RX = v;
    repeat (BIT_CLKS) @(posedge CLK_100MHZ);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) line_bit(1'b1);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_v);
    line_bit(1'b0);
    for (int i = 0; i < DB; i++) line_bit(d[i]);
    if (HAS_PAR) line_bit(par_v);
    for (int i = 0; i < SB; i++) line_bit(stop_v);
    UART_RX = 1'b1;
  endtask

  task automatic model_frame(input logic [DB-1:0] d, input logic stop_v, input logic par_v);
    if (m_pend) m_ovr = 1'b1;
    m_pend = 1'b1;
    m_data = d;
    m_fe   = ~stop_v;
    m_pe   = HAS_PAR ? (((^d) ^ par_v) != 1'(PODD)) : 1'b0;
  endtask

  task automatic model_ack();
    if (m_pend) begin
      m_pend = 1'b0;
      m_ovr  = 1'b0;
    end
  endtask

  task automatic do_ack();
    @(negedge CLK_100MHZ);
    data_ack = 1'b1;
    @(negedge CLK_100MHZ);
    data_ack = 1'b0;
  endtask

  task automatic check_model(input string tag);
    @(negedge CLK_100MHZ);
    check({tag, ".data"},  32'(data_out),    32'(m_data));
    check({tag, ".valid"}, 32'(data_valid),  32'(m_pend));
    check({tag, ".fe"},    32'(frame_err),   32'(m_fe));
    check({tag, ".pe"},    32'(parity_err),  32'(m_pe));
    check({tag, ".ovr"},   32'(overrun_err), 32'(m_ovr));
  endtask

  typedef struct {
    logic [DB-1:0] d;
    logic          stop_v;
    logic          ack;
    logic [DB-1:0] exp_data;
    logic          exp_fe;
    logic          exp_valid;
    logic          exp_ovr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h96, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1};

    // Reset state.
    repeat (5) @(posedge CLK_100MHZ);
    @(negedge CLK_100MHZ);
    reset = 1'b0;
    @(negedge CLK_100MHZ);
    check("rst.data",  32'(data_out),    32'h0);
    check("rst.valid", 32'(data_valid),  32'h0);
    check("rst.fe",    32'(frame_err),   32'h0);
    check("rst.pe",    32'(parity_err),  32'h0);
    check("rst.ovr",   32'(overrun_err), 32'h0);
    idle_bits(2);

    // Directed table: good frame, framing error, recovery, overrun.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].d, tbl[i].stop_v, good_par(tbl[i].d));
      idle_bits(2);
      model_frame(tbl[i].d, tbl[i].stop_v, good_par(tbl[i].d));
      @(negedge CLK_100MHZ);
      check($sformatf("tbl%0d.data", i),  32'(data_out),    32'(tbl[i].exp_data));
      check($sformatf("tbl%0d.fe", i),    32'(frame_err),   32'(tbl[i].exp_fe));
      check($sformatf("tbl%0d.valid", i), 32'(data_valid),  32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d.ovr", i),   32'(overrun_err), 32'(tbl[i].exp_ovr));
      check($sformatf("tbl%0d.pe", i),    32'(parity_err),  32'h0);
      if (tbl[i].ack) begin
        do_ack();
        model_ack();
        check($sformatf("tbl%0d.ack_valid", i), 32'(data_valid),  32'h0);
        check($sformatf("tbl%0d.ack_ovr", i),   32'(overrun_err), 32'h0);
      end
    end

    // Ack while nothing is pending is ignored.
    do_ack();
    check("idle_ack.valid", 32'(data_valid), 32'h0);

    // False start: line low for 4 ticks only.
    UART_RX = 1'b0;
    repeat (16) @(posedge CLK_100MHZ);
    UART_RX = 1'b1;
    idle_bits(2);
    check_model("false_start");
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    idle_bits(2);
    model_frame(8'h3C, 1'b1, good_par(8'h3C));
    check_model("after_false");
    do_ack();
    model_ack();

`ifdef MLUART_RX_PARITY_EN
    // Parity bit both ways on 0x07.
    for (int p = 0; p < 2; p++) begin
      send_frame(8'h07, 1'b1, 1'(p));
      idle_bits(2);
      model_frame(8'h07, 1'b1, 1'(p));
      check_model($sformatf("parity%0d", p));
      do_ack();
      model_ack();
    end
`endif

    // Randomised frames against the model.
    for (int n = 0; n < 20; n++) begin
      logic [DB-1:0] d;
      logic          sv;
      logic          pv;
      d  = DB'($urandom_range(0, 255));
      sv = ($urandom_range(0, 3) != 0);
      pv = (HAS_PAR && ($urandom_range(0, 3) == 0)) ? ~good_par(d) : good_par(d);
      send_frame(d, sv, pv);
      idle_bits($urandom_range(1, 3));
      model_frame(d, sv, pv);
      check_model($sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        model_ack();
        check($sformatf("rnd%0d.ack_valid", n), 32'(data_valid),  32'h0);
        check($sformatf("rnd%0d.ack_ovr", n),   32'(overrun_err), 32'(m_ovr));
      end
    end

    // Reset in the middle of data bit 3 of a frame while a word is pending.
    send_frame(8'h77, 1'b1, good_par(8'h77));
    idle_bits(2);
    model_frame(8'h77, 1'b1, good_par(8'h77));
    check_model("pre_reset");
    line_bit(1'b0);
    line_bit(1'b0);
    line_bit(1'b1);
    line_bit(1'b0);
    UART_RX = 1'b1;
    repeat (BIT_CLKS / 2) @(posedge CLK_100MHZ);
    @(negedge CLK_100MHZ);
    reset = 1'b1;
    repeat (2) @(negedge CLK_100MHZ);
    reset = 1'b0;
    @(negedge CLK_100MHZ);
    check("midrst.data",  32'(data_out),    32'h0);
    check("midrst.valid", 32'(data_valid),  32'h0);
    check("midrst.fe",    32'(frame_err),   32'h0);
    check("midrst.ovr",   32'(overrun_err), 32'h0);
    m_pend = 1'b0;
    m_ovr  = 1'b0;
    idle_bits(3);
    send_frame(8'h5A, 1'b1, good_par(8'h5A));
    idle_bits(2);
    model_frame(8'h5A, 1'b1, good_par(8'h5A));
    check_model("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
